// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: access sizes,
// FSM states and the latched operation descriptor.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        MEMU_IDLE = 2'b00,
        MEMU_REQ  = 2'b01,
        MEMU_DONE = 2'b10
    } memu_state_e;

    typedef struct packed {
        logic       is_store;
        size_e      size;
        logic       is_unsigned;
        logic [1:0] addr_lo;
    } mem_op_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed req/ack data-memory port between the access unit and memory.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    import mem_access_unit_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables and replication, load lane
// extraction with sign/zero extension, and alignment checking.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  size_e             size_i,
    input  logic              is_unsigned_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_c,
    output logic              misaligned_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_c         = '0;
        wdata_c      = '0;
        load_c       = rdata_i;
        misaligned_c = 1'b0;
        byte_sel     = rdata_i[7:0];
        half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase

        case (size_i)
            SIZE_B: begin
                be_c    = 4'b0001 << addr_lo_i;
                wdata_c = {4{wdata_i[7:0]}};
                load_c  = is_unsigned_i ? {24'd0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                be_c         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{wdata_i[15:0]}};
                load_c       = is_unsigned_i ? {16'd0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
                misaligned_c = addr_lo_i[0];
            end
            SIZE_W: begin
                be_c         = 4'b1111;
                wdata_c      = wdata_i;
                misaligned_c = (addr_lo_i != 2'b00);
            end
            default: misaligned_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: accepts one load/store per start strobe,
// runs it over the req/ack port with a bounded wait, and reports done/errors.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned,
    output logic              timeout,
    mem_access_unit_if.master mem
);

    memu_state_e      state_q;
    mem_op_t          op_q;
    logic [CNT_W-1:0] cnt_q;

    logic              idle_c;
    size_e             al_size_c;
    logic              al_unsigned_c;
    logic [1:0]        al_addr_lo_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_c;
    logic              misaligned_c;

    // Lane logic sees the live request while idle and the latched op afterwards.
    always_comb begin
        idle_c        = (state_q == MEMU_IDLE);
        al_size_c     = idle_c ? size_e'(size) : op_q.size;
        al_unsigned_c = idle_c ? is_unsigned : op_q.is_unsigned;
        al_addr_lo_c  = idle_c ? addr[1:0] : op_q.addr_lo;
    end

    mem_lane_align u_lane_align (
        .size_i        (al_size_c),
        .is_unsigned_i (al_unsigned_c),
        .addr_lo_i     (al_addr_lo_c),
        .wdata_i       (wdata),
        .rdata_i       (mem.mem_rdata),
        .be_c          (be_c),
        .wdata_c       (wdata_c),
        .load_c        (load_c),
        .misaligned_c  (misaligned_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MEMU_IDLE;
            op_q          <= '0;
            cnt_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_data     <= '0;
            misaligned    <= 1'b0;
            timeout       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                MEMU_IDLE: begin
                    if (start) begin
                        op_q       <= '{is_store: is_store, size: size_e'(size),
                                        is_unsigned: is_unsigned, addr_lo: addr[1:0]};
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        misaligned <= misaligned_c;
                        timeout    <= 1'b0;
                        if (misaligned_c) begin
                            state_q <= MEMU_DONE;
                        end else begin
                            state_q       <= MEMU_REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_store;
                            mem.mem_addr  <= addr[ADDR_W-1:2];
                            mem.mem_be    <= is_store ? be_c : '0;
                            mem.mem_wdata <= is_store ? wdata_c : '0;
                        end
                    end
                end

                MEMU_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= MEMU_DONE;
                        if (!op_q.is_store) begin
                            load_data <= load_c;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        timeout     <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= MEMU_DONE;
                    end
                end

                // Arrival from REQ already raised done; a misaligned op arrives
                // with done low and spends one extra cycle here to raise it.
                MEMU_DONE: begin
                    if (done) begin
                        busy    <= 1'b0;
                        state_q <= MEMU_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: state_q <= MEMU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue of expected completions
// built from an independent byte-lane model of the memory access.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 4;
    localparam int unsigned MAX_CYC = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          is_store;
    logic [1:0]    size;
    logic          is_unsigned;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [31:0]   load_data;
    logic          misaligned;
    logic          timeout;

    mem_access_unit_if #(.ADDR_W(AW)) mif ();

    mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_store    (is_store),
        .size        (size),
        .is_unsigned (is_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .timeout     (timeout),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        int          req_cyc;
        logic [31:0] ld;
        logic        mis;
        logic        to;
        logic [29:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic        we;
        logic        st;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_ld = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte lanes covered by an access of 2**sz bytes, aligned down to its size.
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
        int n, base;
        logic [3:0] r;
        n    = 1 << sz;
        base = int'(lo) & ~(n - 1);
        for (int i = 0; i < 4; i++) r[i] = (i >= base) && (i < base + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] rd);
        int n;
        logic [31:0] v, r;
        logic sgn;
        n   = 1 << sz;
        v   = rd >> (8 * int'(lo));
        sgn = v[8*n-1];
        for (int i = 0; i < 32; i++) r[i] = (i < 8*n) ? v[i] : (uns ? 1'b0 : sgn);
        return r;
    endfunction

    task automatic run_op(input string nm, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_k, input logic [31:0] rd, input int busy_cyc);
        exp_t        e, g;
        logic        mis;
        bit          ok, got_done, seen_req, stable;
        int          done_c, req_c, first_req;
        logic [29:0] f_addr;
        logic [3:0]  f_be;
        logic [31:0] f_wd;
        logic        f_we;

        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        ok  = !mis && ack_k >= 1 && ack_k <= int'(TMO);
        if (ok && !st) model_ld = m_load(sz, uns, a[1:0], rd);
        e.mis      = mis;
        e.to       = !mis && !ok;
        e.done_cyc = mis ? 2 : (ok ? ack_k + 1 : int'(TMO) + 1);
        e.req_cyc  = mis ? 0 : (ok ? ack_k : int'(TMO));
        e.ld       = model_ld;
        e.maddr    = a[31:2];
        e.be       = st ? m_be(sz, a[1:0]) : 4'b0000;
        e.mwd      = m_wd(sz, wd);
        e.we       = st;
        e.st       = st;
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
        got_done = 0; seen_req = 0; stable = 1; done_c = 0; req_c = 0; first_req = 0;
        f_addr = '0; f_be = '0; f_wd = '0; f_we = 1'b0;
        for (int c = 1; c <= int'(MAX_CYC); c++) begin
            @(negedge clk);
            if (c == 1) chk({nm, ":busy_c1"}, 32'(busy), 32'd1);
            start = (c == busy_cyc);
            if (start) begin
                is_store = ~st; size = 2'b10; is_unsigned = ~uns;
                addr = 32'hFFFF_FFF0; wdata = 32'h5555_5555;
            end
            if (mif.mem_req) begin
                if (!seen_req) begin
                    first_req = c; f_addr = mif.mem_addr; f_be = mif.mem_be;
                    f_wd = mif.mem_wdata; f_we = mif.mem_we;
                end else if (f_addr !== mif.mem_addr || f_be !== mif.mem_be ||
                             f_wd !== mif.mem_wdata || f_we !== mif.mem_we) begin
                    stable = 0;
                end
                seen_req = 1;
                req_c++;
            end
            mif.mem_ack   = mif.mem_req && (c == ack_k);
            mif.mem_rdata = (c == ack_k) ? rd : 32'h0BAD_0BAD;
            if (done) begin
                done_c = c; got_done = 1; break;
            end
        end
        mif.mem_ack = 1'b0;
        start = 1'b0;

        g = sb.pop_front();
        chk({nm, ":done_seen"}, 32'(got_done), 32'd1);
        chk({nm, ":done_cycle"}, 32'(done_c), 32'(g.done_cyc));
        chk({nm, ":req_cycles"}, 32'(req_c), 32'(g.req_cyc));
        chk({nm, ":load_data"}, load_data, g.ld);
        chk({nm, ":misaligned"}, 32'(misaligned), 32'(g.mis));
        chk({nm, ":timeout"}, 32'(timeout), 32'(g.to));
        if (g.req_cyc > 0) begin
            chk({nm, ":first_req"}, 32'(first_req), 32'd1);
            chk({nm, ":req_stable"}, 32'(stable), 32'd1);
            chk({nm, ":mem_addr"}, 32'(f_addr), 32'(g.maddr));
            chk({nm, ":mem_be"}, 32'(f_be), 32'(g.be));
            chk({nm, ":mem_we"}, 32'(f_we), 32'(g.we));
            if (g.st) chk({nm, ":mem_wdata"}, f_wd, g.mwd);
        end
        @(negedge clk);
        chk({nm, ":done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, ":busy_after"}, 32'(busy), 32'd0);
        if (busy_cyc != 0) begin
            repeat (2) begin
                @(negedge clk);
                chk({nm, ":no_extra_op"}, 32'({done, busy, mif.mem_req}), 32'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; is_unsigned = 1'b0;
        addr = '0; wdata = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:load_data", load_data, 32'd0);
        chk("rst:errors", 32'({misaligned, timeout}), 32'd0);
        chk("rst:mem_req", 32'({mif.mem_req, mif.mem_we}), 32'd0);
        chk("rst:mem_be", 32'(mif.mem_be), 32'd0);
        chk("rst:mem_addr", 32'(mif.mem_addr), 32'd0);
        reset = 1'b0;

        //     name         st    sz     uns   addr          wdata         ack rdata        busy
        run_op("st_b",      1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 32'h0,         0);
        run_op("ld_h_s",    1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         1, 32'h8001_7FFF, 0);
        run_op("ld_h_u",    1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         2, 32'h8001_7FFF, 0);
        run_op("ld_b_dly",  1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         3, 32'h1234_5678, 0);
        run_op("mis_w",     1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         1, 32'hFFFF_FFFF, 0);
        run_op("mis_sz3",   1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h1111_2222, 1, 32'h0,         0);
        run_op("ld_w_tmo",  1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         0, 32'h0,         0);
        run_op("ld_w_last", 1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0,         4, 32'hDEAD_BEEF, 0);
        run_op("st_h_busy", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 2, 32'h0,         2);
        run_op("st_w",      1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 1, 32'h0,         0);
        run_op("ld_b_neg",  1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,         2, 32'h80FF_0000, 0);
        run_op("ld_h_hi_u", 1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0,         1, 32'hF00D_1234, 0);
        run_op("st_tmo",    1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_0077, 0, 32'h0,         0);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b10; is_unsigned = 1'b0; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid:req_before", 32'(mif.mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid:mem_req", 32'(mif.mem_req), 32'd0);
        chk("rstmid:busy", 32'(busy), 32'd0);
        chk("rstmid:done", 32'(done), 32'd0);
        chk("rstmid:load_data", load_data, 32'd0);
        reset = 1'b0;
        model_ld = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid:no_done", 32'({done, busy}), 32'd0);
        end
        run_op("post_rst",  1'b0, 2'b00, 1'b1, 32'h0000_0042, 32'h0,         1, 32'hA1B2_C3D4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access unit for the MEM stage of the multi-cycle core. Triggered by the one-cycle RAM write-enable strobe from the stage controller.
- Performs aligned byte/half/word loads and stores over a req/ack memory port.
- Returns sign- or zero-extended load data, plus done/error status, to the MEM/WB register.

Parameters:
ADDR_W, 32, byte-address width; memory word address is addr[ADDR_W-1:2]
TIMEOUT, 255, max cycles to wait for mem_ack before aborting (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request strobe (driven from stage controller ram_wren)
is_store  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
is_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-justified
busy  out  1  high while state != IDLE
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, held until next successful load
misaligned  out  1  error flag, valid with done, held until next accepted start
timeout  out  1  error flag, valid with done, held until next accepted start
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  write request
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables (stores), 0000 for loads
mem_ack  in  1  memory accepted/returned; sampled only while mem_req=1
mem_rdata  in  32  read word, valid in mem_ack cycle

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-operation drops mem_req at the next edge; no done pulse.
- FSM states IDLE, REQ, DONE, all registered. Every output is a register.
- IDLE + start:
  - Latch the op, clear misaligned and timeout.
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always misaligned.
  - Misaligned: next state DONE, misaligned=1, no mem_req ever.
  - Aligned: next state REQ with mem_req=1 and mem_we/addr/be/wdata driven.
- start while busy: ignored; no effect on the latched op.
- REQ:
  - mem_req held with stable outputs. Counter increments each REQ cycle.
  - mem_ack=1 → mem_req=0 next edge, state DONE. For a load, capture the extended data into load_data on this edge.
  - If the counter reaches TIMEOUT without an ack → mem_req=0, timeout=1, state DONE. load_data is unchanged.
  - Ack in the same cycle as the count hits TIMEOUT: the ack wins.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the cycle after done.
- Latency, with start at cycle 0:
  - mem_req rises at cycle 1.
  - An ack at cycle k puts done at cycle k+1.
  - Minimum start→done is 2 cycles. A misaligned op gives done at cycle 2.
- Store lanes, little-endian:
  - Byte: be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 (addr[1]=0) or 1100, mem_wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- Loads: select the byte/half lane by addr[1:0]/addr[1], then extend to 32 bits per is_unsigned. Word loads pass through. mem_rdata is ignored for stores.

Decomposition:
- Shared define header: size encodings (SIZE_B/H/W), FSM state encodings (MEMU_IDLE/REQ/DONE).
- One combinational sub-module, mem_lane_align: store be/wdata generation, load lane extraction and extension, misalignment detect.
- FSM and counter stay in mem_access_unit.

Test Plan:
- Store byte: addr=0x0000_1003, wdata=0x0000_00A5, ack at cycle 1 → mem_addr=0x400, be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, done at cycle 2, no errors.
- Load half signed: addr=0x102, mem_rdata=0x8001_7FFF → load_data=0xFFFF_8001. Repeat with is_unsigned=1 → 0x0000_8001.
- Load byte after 3-cycle ack delay: addr=0x101, rdata=0x1234_5678 → mem_req high cycles 1-3, load_data=0x0000_0056, done at cycle 4.
- Misaligned word: addr=0x102 → no mem_req, done at cycle 2, misaligned=1. Also size=11 at addr 0 → misaligned=1.
- Timeout: TIMEOUT=4, never ack → mem_req high exactly 4 cycles, done with timeout=1, load_data unchanged. Ack on the 4th cycle → success.
- start pulsed while busy is ignored. reset asserted mid-REQ → mem_req=0 and busy=0 next edge, no done pulse.
